// File: rtl/hermes_credit_crossbar_pkg.sv
// Shared types and helpers for the Hermes credit-tracking crossbar.
// Connection states and port-index sizing.
package hermes_credit_crossbar_pkg;

    typedef enum logic {
        FREE = 1'b0,
        BUSY = 1'b1
    } hermes_conn_t;

    function automatic int port_width(input int nport);
        return (nport > 1) ? $clog2(nport) : 1;
    endfunction

endpackage

// File: rtl/hermes_credit_crossbar_credit_counter.sv
// Per-output downstream credit counter with saturation.
// Overflow is reported as a single-cycle pulse.
module hermes_credit_counter #(
    parameter int CREDITS = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic send_i,
    input  logic credit_i,
    output logic avail_o,
    output logic ovf_o
);

    localparam int CW = $clog2(CREDITS + 1);
    localparam logic [CW-1:0] MAX = CW'(CREDITS);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        ovf_o = 1'b0;
        case ({send_i, credit_i})
            2'b10: cnt_d = cnt_q - CW'(1);
            2'b01: begin
                if (cnt_q == MAX) ovf_o = 1'b1;
                else cnt_d = cnt_q + CW'(1);
            end
            default: cnt_d = cnt_q;
        endcase
    end

    assign avail_o = (cnt_q != '0);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) cnt_q <= MAX;
        else cnt_q <= cnt_d;
    end

endmodule

// File: rtl/hermes_credit_crossbar.sv
// Registered, credit-tracking Hermes crossbar: per-output connection
// table, owner mux, combinational ack and registered output flits.
module hermes_credit_crossbar
    import hermes_credit_crossbar_pkg::*;
#(
    parameter int NPORT = 5,
    parameter int FLIT_SIZE = 32,
    parameter int CREDITS = 4,
    localparam int PW = port_width(NPORT)
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [NPORT-1:0]           req_i,
    input  logic [NPORT*FLIT_SIZE-1:0] data_i,
    output logic [NPORT-1:0]           ack_o,
    input  logic [NPORT-1:0]           connect_i,
    input  logic [NPORT*PW-1:0]        connect_port_i,
    input  logic [NPORT-1:0]           release_i,
    input  logic [NPORT-1:0]           credit_i,
    output logic [NPORT-1:0]           free_o,
    output logic [NPORT-1:0]           tx_o,
    output logic [NPORT*FLIT_SIZE-1:0] data_o,
    output logic                       err_o
);

    localparam int FW = FLIT_SIZE;

    hermes_conn_t   conn_q  [NPORT];
    logic [PW-1:0]  owner_q [NPORT];
    logic [PW-1:0]  cport   [NPORT];
    logic [FW-1:0]  flit    [NPORT];

    logic [NPORT-1:0]    owner_req, port_ok, proto_err;
    logic [NPORT-1:0]    dup, send, avail, ovf;
    logic [NPORT-1:0]    tx_q;
    logic [NPORT*FW-1:0] data_q;
    logic                err_q, err_d;

    always_comb begin
        for (int o = 0; o < NPORT; o++) begin
            owner_req[o] = 1'b0;
            flit[o] = '0;
            for (int p = 0; p < NPORT; p++) begin
                if (owner_q[o] == PW'(p)) begin
                    owner_req[o] = req_i[p];
                    flit[o] = data_i[p*FW +: FW];
                end
            end
        end
    end

    // An input shared by several bound outputs is served by the lowest one.
    always_comb begin
        dup = '0;
        send = '0;
        ack_o = '0;
        for (int o = 0; o < NPORT; o++) begin
            for (int j = 0; j < o; j++) begin
                if (conn_q[j] == BUSY && conn_q[o] == BUSY &&
                    owner_q[j] == owner_q[o])
                    dup[o] = 1'b1;
            end
            send[o] = (conn_q[o] == BUSY) & owner_req[o]
                    & avail[o] & ~dup[o];
            for (int p = 0; p < NPORT; p++) begin
                if (send[o] && owner_q[o] == PW'(p)) ack_o[p] = 1'b1;
            end
        end
    end

    always_comb begin
        for (int o = 0; o < NPORT; o++) begin
            cport[o] = connect_port_i[o*PW +: PW];
            port_ok[o] = int'(cport[o]) < NPORT;
            free_o[o] = (conn_q[o] == FREE);
            proto_err[o] = (connect_i[o] & ~port_ok[o])
                | ((conn_q[o] == FREE) & release_i[o] & ~connect_i[o])
                | ((conn_q[o] == BUSY) & connect_i[o] & ~release_i[o]);
        end
        err_d = err_q | (|proto_err) | (|dup) | (|ovf);
    end

    for (genvar o = 0; o < NPORT; o++) begin : g_cnt
        hermes_credit_counter #(
            .CREDITS(CREDITS)
        ) u_cnt (
            .clk_i   (clk_i),
            .rst_i   (rst_i),
            .send_i  (send[o]),
            .credit_i(credit_i[o]),
            .avail_o (avail[o]),
            .ovf_o   (ovf[o])
        );
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int o = 0; o < NPORT; o++) begin
                conn_q[o] <= FREE;
                owner_q[o] <= '0;
            end
        end else begin
            for (int o = 0; o < NPORT; o++) begin
                case (conn_q[o])
                    FREE: begin
                        if (connect_i[o] && port_ok[o]) begin
                            conn_q[o] <= BUSY;
                            owner_q[o] <= cport[o];
                        end
                    end
                    BUSY: begin
                        if (release_i[o]) begin
                            if (connect_i[o] && port_ok[o])
                                owner_q[o] <= cport[o];
                            else
                                conn_q[o] <= FREE;
                        end
                    end
                    default: conn_q[o] <= FREE;
                endcase
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            tx_q <= '0;
            data_q <= '0;
            err_q <= 1'b0;
        end else begin
            tx_q <= send;
            err_q <= err_d;
            for (int o = 0; o < NPORT; o++) begin
                if (send[o]) data_q[o*FW +: FW] <= flit[o];
            end
        end
    end

    assign tx_o = tx_q;
    assign data_o = data_q;
    assign err_o = err_q;

endmodule

// File: tb/tb_hermes_credit_crossbar.sv
// Self-checking bench for hermes_credit_crossbar: directed scenarios
// plus randomized traffic against a behavioural reference model.
module tb_hermes_credit_crossbar;

    localparam int N = 5;
    localparam int FW = 32;
    localparam int CR = 4;
    localparam int PW = 3;
    localparam int CPW = N * PW;
    localparam int DW = N * FW;

    logic clk = 1'b0;
    logic rst;
    logic [N-1:0] req, ack, connect, rel, credit, free, tx;
    logic [DW-1:0] data_in, data_out;
    logic [CPW-1:0] cport;
    logic err;

    int total = 0;
    int passed = 0;

    bit m_busy [N];
    int m_own [N];
    int m_cnt [N];
    bit m_err;
    logic [FW-1:0] m_data [N];
    bit [N-1:0] m_tx, m_send, m_ack;
    bit m_dup;
    logic [N-1:0] last_ack;

    always #5 clk = ~clk;

    hermes_credit_crossbar #(
        .NPORT(N), .FLIT_SIZE(FW), .CREDITS(CR)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .req_i(req), .data_i(data_in), .ack_o(ack),
        .connect_i(connect), .connect_port_i(cport),
        .release_i(rel), .credit_i(credit),
        .free_o(free), .tx_o(tx), .data_o(data_out),
        .err_o(err)
    );

    task automatic check(input string tag, input logic [255:0] obs,
                         input logic [255:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic logic [N-1:0] m_free();
        logic [N-1:0] f;
        for (int o = 0; o < N; o++) f[o] = !m_busy[o];
        return f;
    endfunction

    function automatic logic [DW-1:0] m_dout();
        logic [DW-1:0] d;
        for (int o = 0; o < N; o++) d[o*FW +: FW] = m_data[o];
        return d;
    endfunction

    function automatic void model_reset();
        for (int o = 0; o < N; o++) begin
            m_busy[o] = 0; m_own[o] = 0; m_cnt[o] = CR; m_data[o] = '0;
        end
        m_err = 0; m_tx = '0;
    endfunction

    // Which outputs forward this cycle: each input serves at most one bound
    // output (the lowest), and only while that output has credit.
    function automatic void model_comb();
        bit claimed [N];
        for (int p = 0; p < N; p++) claimed[p] = 0;
        m_send = '0; m_ack = '0; m_dup = 0;
        for (int o = 0; o < N; o++) begin
            if (m_busy[o]) begin
                if (claimed[m_own[o]]) m_dup = 1;
                else begin
                    claimed[m_own[o]] = 1;
                    if (req[m_own[o]] && m_cnt[o] > 0) begin
                        m_send[o] = 1;
                        m_ack[m_own[o]] = 1;
                    end
                end
            end
        end
    endfunction

    function automatic void model_update();
        int nc, p;
        bit ok;
        if (m_dup) m_err = 1;
        for (int o = 0; o < N; o++) begin
            m_tx[o] = m_send[o];
            if (m_send[o]) m_data[o] = data_in[m_own[o]*FW +: FW];
            nc = m_cnt[o] - int'(m_send[o]) + int'(credit[o]);
            if (nc > CR) begin nc = CR; m_err = 1; end
            m_cnt[o] = nc;
            p = int'(cport[o*PW +: PW]);
            ok = p < N;
            if (connect[o] && !ok) m_err = 1;
            if (m_busy[o]) begin
                if (rel[o]) begin
                    if (connect[o] && ok) m_own[o] = p;
                    else m_busy[o] = 0;
                end else if (connect[o]) m_err = 1;
            end else begin
                if (connect[o] && ok) begin m_busy[o] = 1; m_own[o] = p; end
                else if (rel[o] && !connect[o]) m_err = 1;
            end
        end
    endfunction

    task automatic tick();
        @(negedge clk);
        model_comb();
        last_ack = ack;
        check("ack", 256'(ack), 256'(m_ack));
        check("free", 256'(free), 256'(m_free()));
        model_update();
        @(posedge clk);
        #1;
        check("tx", 256'(tx), 256'(m_tx));
        check("data", 256'(data_out), 256'(m_dout()));
        check("err", 256'(err), 256'(m_err));
    endtask

    task automatic idle_inputs();
        req = '0; connect = '0; rel = '0; credit = '0; cport = '0;
    endtask

    task automatic set_port(input int o, input int p);
        cport[o*PW +: PW] = PW'(p);
    endtask

    task automatic set_data(input int p, input logic [FW-1:0] v);
        data_in[p*FW +: FW] = v;
    endtask

    // Reset asserted between clock edges must act immediately.
    task automatic do_reset();
        rst = 1'b1;
        #1;
        check("rst_free", 256'(free), 256'(5'h1f));
        check("rst_tx", 256'(tx), 256'(0));
        check("rst_err", 256'(err), 256'(0));
        check("rst_ack", 256'(ack), 256'(0));
        check("rst_data", 256'(data_out), 256'(0));
        model_reset();
        idle_inputs();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        int sent, acks;
        logic [FW-1:0] recv [$];
        bit taken [N];
        int p;

        idle_inputs();
        data_in = '0;
        do_reset();

        // Output 2 <- input 0, stream with no credit return.
        connect[2] = 1; set_port(2, 0);
        tick();
        idle_inputs();
        sent = 0;
        for (int k = 0; k < 8; k++) begin
            req[0] = 1; set_data(0, FW'(32'hA0 + sent));
            tick();
            if (last_ack[0]) sent++;
            if (tx[2]) recv.push_back(data_out[2*FW +: FW]);
        end
        check("stall_acks", 256'(sent), 256'(4));
        check("stall_recv_n", 256'(recv.size()), 256'(4));
        for (int i = 0; i < recv.size() && i < 4; i++)
            check("stall_recv", 256'(recv[i]), 256'(32'hA0 + i));

        // Credit returned while empty becomes usable only next cycle.
        credit[2] = 1;
        tick();
        check("credit_same_cycle", 256'(last_ack[0]), 256'(0));
        credit[2] = 0;
        tick();
        check("credit_next_ack", 256'(last_ack[0]), 256'(1));
        check("credit_next_data", 256'(data_out[2*FW +: FW]), 256'(32'hA4));
        tick();
        check("stall_again", 256'(last_ack[0]), 256'(0));

        // One credit in hand, then send and credit every cycle.
        req[0] = 0; credit[2] = 1;
        tick();
        acks = 0;
        for (int k = 0; k < 10; k++) begin
            req[0] = 1; credit[2] = 1; set_data(0, FW'(32'hD0 + k));
            tick();
            if (last_ack[0]) acks++;
        end
        check("balanced_acks", 256'(acks), 256'(10));

        // Tail from input 0 with back-to-back rebind to input 3.
        req = 5'b01001; set_data(0, 32'hBB); set_data(3, 32'hC3);
        rel[2] = 1; connect[2] = 1; set_port(2, 3); credit[2] = 1;
        tick();
        check("tail_ack", 256'(last_ack[0]), 256'(1));
        check("tail_data", 256'(data_out[2*FW +: FW]), 256'(32'hBB));
        check("rebind_busy", 256'(free[2]), 256'(0));
        idle_inputs(); req[3] = 1;
        tick();
        check("new_owner_ack", 256'(last_ack[3]), 256'(1));
        check("new_owner_data", 256'(data_out[2*FW +: FW]), 256'(32'hC3));
        check("no_err_yet", 256'(err), 256'(0));

        // Connect on a busy output: ignored, owner kept.
        idle_inputs(); connect[2] = 1; set_port(2, 1);
        tick();
        check("err_connect_busy", 256'(err), 256'(1));
        idle_inputs(); credit[2] = 1;
        tick();
        idle_inputs(); req = 5'b01010; set_data(3, 32'hC4);
        tick();
        check("owner_kept", 256'(last_ack), 256'(5'b01000));
        tick();
        check("err_sticky", 256'(err), 256'(1));
        do_reset();

        // Release on a free output.
        rel[1] = 1;
        tick();
        check("err_release_free", 256'(err), 256'(1));
        check("free_unchanged", 256'(free), 256'(5'h1f));
        do_reset();

        // Credit overflow: counter must still hold exactly CREDITS.
        credit[0] = 1;
        tick();
        check("err_overflow", 256'(err), 256'(1));
        idle_inputs(); connect[0] = 1; set_port(0, 1);
        tick();
        idle_inputs();
        acks = 0;
        for (int k = 0; k < 6; k++) begin
            req[1] = 1; set_data(1, FW'(32'hE0 + k));
            tick();
            if (last_ack[1]) acks++;
        end
        check("overflow_cnt_held", 256'(acks), 256'(CR));
        do_reset();

        // Outputs 1 and 4 both owned by input 2.
        connect = 5'b10010; set_port(1, 2); set_port(4, 2);
        tick();
        idle_inputs();
        for (int k = 0; k < 3; k++) begin
            req[2] = 1; set_data(2, FW'(32'hF0 + k));
            tick();
            check("dup_ack", 256'(last_ack), 256'(5'b00100));
            check("dup_tx", 256'(tx), 256'(5'b00010));
            check("dup_err", 256'(err), 256'(1));
        end
        do_reset();

        // Randomized legal traffic.
        for (int c = 0; c < 400; c++) begin
            for (int o = 0; o < N; o++) taken[o] = 0;
            for (int o = 0; o < N; o++) if (m_busy[o]) taken[m_own[o]] = 1;
            idle_inputs();
            req = N'($urandom);
            for (int q = 0; q < N; q++) set_data(q, $urandom);
            for (int o = 0; o < N; o++) begin
                p = $urandom_range(N - 1);
                if (m_busy[o] && $urandom_range(7) == 0) begin
                    rel[o] = 1;
                    if ($urandom_range(1) == 1 && !taken[p]) begin
                        connect[o] = 1; set_port(o, p); taken[p] = 1;
                    end
                end else if (!m_busy[o] && $urandom_range(3) == 0
                             && !taken[p]) begin
                    connect[o] = 1; set_port(o, p); taken[p] = 1;
                end
                credit[o] = (m_cnt[o] < CR) && ($urandom_range(1) == 1);
            end
            tick();
        end
        check("legal_no_err", 256'(err), 256'(0));
        do_reset();

        // Randomized unconstrained traffic, protocol errors included.
        for (int c = 0; c < 200; c++) begin
            req = N'($urandom);
            for (int q = 0; q < N; q++) set_data(q, $urandom);
            connect = N'($urandom & $urandom & $urandom);
            rel = N'($urandom & $urandom);
            credit = N'($urandom & $urandom);
            cport = CPW'($urandom);
            tick();
        end
        do_reset();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/hermes_credit_crossbar.md
Name: hermes_credit_crossbar

Overview:
- Registered, credit-tracking successor to the combinational Hermes switch fabric. Sits between the input buffers and the output links of a router.
- Holds a per-output connection table, set and released by the switch allocator.
- Tracks downstream buffer credits per output with a counter, so input buffers no longer wait on a combinational credit path.
- Registers every output flit (1-cycle latency) and flags protocol violations.

Parameters:
- NPORT, 5, number of router ports (inputs = outputs).
- FLIT_SIZE, 32, flit width in bits.
- CREDITS, 4, downstream buffer depth; counter reset value and maximum.
- Derived localparams: PW = $clog2(NPORT) (port index width); CW = $clog2(CREDITS+1) (counter width).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous, active-high reset.
- req_i  in  [NPORT]x1  input buffer p presents a valid flit.
- data_i  in  [NPORT]xFLIT_SIZE  input flit.
- ack_o  out  [NPORT]x1  input flit consumed this cycle.
- connect_i  in  [NPORT]x1  allocator request to bind output o.
- connect_port_i  in  [NPORT]xPW  input index for connect_i[o].
- release_i  in  [NPORT]x1  unbind output o (tail flit sent).
- credit_i  in  [NPORT]x1  one-cycle credit-return pulse from the downstream of output o.
- free_o  out  [NPORT]x1  output o unbound.
- tx_o  out  [NPORT]x1  registered valid for output o.
- data_o  out  [NPORT]xFLIT_SIZE  registered flit for output o.
- err_o  out  1  sticky protocol-error flag.

Behaviour:
- Reset (async, rst_i=1):
  - All outputs are FREE; free_o = all 1.
  - Credit counters = CREDITS.
  - tx_o = 0, data_o = 0, err_o = 0.
  - ack_o is combinational and therefore 0, since no output is bound.
  - Reset mid-packet discards the connection and the in-flight flit. No credit reconciliation is done.
- Per-output state machine (FREE/BUSY) plus owner register (PW bits):
  - FREE & connect_i -> BUSY; owner = connect_port_i.
  - BUSY & release_i -> FREE.
  - BUSY & release_i & connect_i (same cycle) -> stays BUSY with the new owner (back-to-back packets).
  - FREE & release_i alone -> ignored and sets err_o.
  - BUSY & connect_i without release_i -> ignored and sets err_o.
  - connect_port_i >= NPORT -> ignored and sets err_o.
- Forwarding (combinational ack, registered data):
  - send[o] = BUSY[o] & req_i[owner[o]] & (cnt[o] != 0).
  - ack_o[p] = OR over o of (send[o] & owner[o]==p).
  - If two BUSY outputs share an owner: set err_o; only the lowest-index output forwards and acks.
  - On send[o]: next cycle tx_o[o] = 1 and data_o[o] = data_i[owner]. Otherwise tx_o[o] = 0 and data_o holds its last value.
  - Latency input->output is 1 cycle. Throughput is 1 flit/cycle per output while credits remain.
  - A flit presented in the same cycle as release_i is still forwarded under the old owner. Release takes effect the next cycle.
- Credit counter per output, CW bits:
  - send only -> cnt-1.
  - credit_i only -> cnt+1.
  - send & credit_i -> unchanged.
  - credit_i with cnt==CREDITS and no send -> hold at CREDITS and set err_o (overflow).
  - cnt==0 blocks send. A credit returned in that cycle is usable the following cycle (no combinational credit->ack path).
  - Counters are independent of connection state and persist across packets.
- err_o clears only on reset.

Decomposition:
- HermesPkg gains:
  - typedef hermes_conn_t {FREE, BUSY};
  - function for the port index width, used for PW.
- Natural sub-module: hermes_credit_counter (one instance per output).
  - Handles the send/credit arithmetic, saturation and the overflow flag.
  - The top level holds the connection table, owner mux, ack OR-reduction and output registers.

Test Plan:
- Reset with NPORT=5, CREDITS=4 -> free_o=5'b11111, tx_o all 0, err_o=0. Assert rst_i mid-traffic -> same values immediately, without waiting for a clock edge.
- Connect output 2 to input 0; input 0 streams 6 flits 0xA0..0xA5 with no credits returned -> ack_o[0] high for 4 cycles; tx_o[2] carries 0xA0..0xA3 one cycle later; then stall with ack=0.
- Same stall, then pulse credit_i[2] once -> exactly one more flit (0xA4) is acked the following cycle. Simultaneous send and credit_i hold cnt constant over a 10-flit stream.
- release_i[2] and connect_i[2] (port 3) in the same cycle while input 0 sends its tail -> tail is forwarded from input 0; the next-cycle flit comes from input 3; free_o[2] stays 0.
- Protocol errors, each checked separately -> err_o=1 and stays set, and state is unchanged:
  - connect_i on a BUSY output;
  - release_i on a FREE output;
  - credit_i with cnt=4.
- Outputs 1 and 4 both bound to input 2 -> err_o=1; only output 1 forwards; ack_o[2] pulses once per flit.
